// File: rtl/uart_threshold_bank.sv
// Byte-command bank of NUM_CH signed thresholds between the uart core and the climate datapath.
// Optional macro THB_ERR_NAK_EN: answer unknown command bytes with '?' instead of ignoring them.
module uart_threshold_bank #(
  parameter int NUM_CH   = 7,
  parameter int TH_WIDTH = 16,
  parameter logic [NUM_CH*TH_WIDTH-1:0] TH_DEFAULT =
    {16'sd16, 16'sd35, 16'sd16, 16'sd35, 16'sd16, 16'sd35, 16'sd2550},
  parameter logic [NUM_CH*TH_WIDTH-1:0] TH_STEP =
    {16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd50},
  parameter logic [NUM_CH*TH_WIDTH-1:0] TH_MIN =
    {-16'sd12, 16'sd32, -16'sd12, 16'sd32, -16'sd12, 16'sd32, 16'sd50},
  parameter logic [NUM_CH*TH_WIDTH-1:0] TH_MAX =
    {16'sd27, 16'sd50, 16'sd27, 16'sd50, 16'sd27, 16'sd50, 16'sd5000}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  input  logic                       tx_idle,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  output logic [4:0]                 sel_ch,
  output logic [NUM_CH*TH_WIDTH-1:0] th_flat,
  output logic                       busy,
  output logic [2:0]                 o_dbg_state
);

  typedef enum logic [2:0] {S_IDLE, S_ECHO, S_GAP, S_UPDATE, S_TX, S_TXGAP} state_t;

  localparam int NBYTES = (TH_WIDTH + 7) / 8;
  localparam int EXT_W  = NBYTES * 8;
  localparam int AW     = TH_WIDTH + 2;
  localparam logic [1:0] LAST_IDX = 2'(NBYTES - 1);

  state_t              r_state, w_state_nxt;
  logic [7:0]          r_cmd;
  logic [4:0]          r_sel;
  logic [1:0]          r_idx;
  logic                r_tx_start;
  logic [7:0]          r_tx_data;
  logic [TH_WIDTH-1:0] r_th [NUM_CH];

  logic                w_known, w_accept, w_tx_go;
  logic [7:0]          w_cmd_in, w_tx_byte;
  logic [TH_WIDTH-1:0] w_cur, w_step_raw, w_min_raw, w_max_raw, w_def_raw, w_new;
  logic signed [AW-1:0] w_cur_x, w_step_x, w_min_x, w_max_x, w_cand, w_clamped;
  logic [EXT_W-1:0]    w_val_ext;

  function automatic logic is_sel(input logic [7:0] b);
    logic [7:0] rel;
    rel = b - 8'h41;
    return (b >= 8'h41) && (rel < 8'(NUM_CH));
  endfunction

  function automatic logic is_op(input logic [7:0] b);
    return (b == 8'h77) || (b == 8'h73) || (b == 8'h7A) || (b == 8'h72);
  endfunction

  // rx_valid is a one-cycle strobe with no back-pressure: a byte is consumed only if it lands in
  // S_IDLE. tx_start is a one-cycle strobe issued only after tx_idle was seen high.
  assign w_known = is_sel(rx_data) || is_op(rx_data);
`ifdef THB_ERR_NAK_EN
  assign w_accept = rx_valid;
  assign w_cmd_in = w_known ? rx_data : 8'h3F;
`else
  assign w_accept = rx_valid && w_known;
  assign w_cmd_in = rx_data;
`endif

  assign w_cur      = r_th[r_sel];
  assign w_step_raw = TH_STEP[r_sel*TH_WIDTH +: TH_WIDTH];
  assign w_min_raw  = TH_MIN[r_sel*TH_WIDTH +: TH_WIDTH];
  assign w_max_raw  = TH_MAX[r_sel*TH_WIDTH +: TH_WIDTH];
  assign w_def_raw  = TH_DEFAULT[r_sel*TH_WIDTH +: TH_WIDTH];

  // Widened by two bits so cur +/- step can never wrap before clamping.
  always_comb begin
    w_cur_x  = AW'($signed(w_cur));
    w_step_x = $signed(AW'(w_step_raw));
    w_min_x  = AW'($signed(w_min_raw));
    w_max_x  = AW'($signed(w_max_raw));
    w_cand   = w_cur_x;
    if (r_cmd == 8'h77) w_cand = w_cur_x + w_step_x;
    else if (r_cmd == 8'h73) w_cand = w_cur_x - w_step_x;
    if (w_cand > w_max_x)      w_clamped = w_max_x;
    else if (w_cand < w_min_x) w_clamped = w_min_x;
    else                       w_clamped = w_cand;
    w_new = w_cur;
    if (r_cmd == 8'h7A)                         w_new = w_def_raw;
    else if (r_cmd == 8'h77 || r_cmd == 8'h73)  w_new = TH_WIDTH'(w_clamped);
  end

  assign w_val_ext = EXT_W'($signed(w_cur));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tx_go     = 1'b0;
    w_tx_byte   = r_tx_data;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_ECHO;
      S_ECHO: begin
        if (tx_idle) begin
          w_tx_go     = 1'b1;
          w_tx_byte   = r_cmd;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP:    w_state_nxt = is_op(r_cmd) ? S_UPDATE : S_IDLE;
      S_UPDATE: w_state_nxt = S_TX;
      S_TX: begin
        if (tx_idle) begin
          w_tx_go     = 1'b1;
          w_tx_byte   = w_val_ext[8*r_idx +: 8];
          w_state_nxt = S_TXGAP;
        end
      end
      S_TXGAP:  w_state_nxt = (r_idx == LAST_IDX) ? S_IDLE : S_TX;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd      <= 8'h00;
      r_sel      <= 5'd0;
      r_idx      <= 2'd0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      for (int k = 0; k < NUM_CH; k++) r_th[k] <= TH_DEFAULT[k*TH_WIDTH +: TH_WIDTH];
    end else begin
      r_tx_start <= w_tx_go;
      r_tx_data  <= w_tx_byte;
      if (r_state == S_IDLE && w_accept) r_cmd <= w_cmd_in;
      if (r_state == S_GAP && is_sel(r_cmd)) r_sel <= 5'(r_cmd - 8'h41);
      if (r_state == S_UPDATE) begin
        r_th[r_sel] <= w_new;
        r_idx       <= 2'd0;
      end
      if (r_state == S_TXGAP && r_idx != LAST_IDX) r_idx <= r_idx + 2'd1;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_flat
    assign th_flat[k*TH_WIDTH +: TH_WIDTH] = r_th[k];
  end

  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign sel_ch      = r_sel;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_threshold_bank.sv
// Directed plus randomized bench for uart_threshold_bank (default parameters), checked against
// an integer model of the command rules.
module tb_uart_threshold_bank;

  localparam int NCH = 7;
  localparam int W   = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      rx_data = 8'h00;
  logic            rx_valid = 1'b0;
  logic            tx_idle = 1'b1;
  logic [7:0]      tx_data;
  logic            tx_start;
  logic [4:0]      sel_ch;
  logic [NCH*W-1:0] th_flat;
  logic            busy;
  logic [2:0]      dbg_state;

  uart_threshold_bank dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .tx_idle(tx_idle),
    .tx_data(tx_data), .tx_start(tx_start), .sel_ch(sel_ch), .th_flat(th_flat),
    .busy(busy), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int def_v [NCH] = '{2550, 35, 16, 35, 16, 35, 16};
  int min_v [NCH] = '{50, 32, -12, 32, -12, 32, -12};
  int max_v [NCH] = '{5000, 50, 27, 50, 27, 50, 27};
  int step_v[NCH] = '{50, 1, 1, 1, 1, 1, 1};

  int m_th[NCH];
  int m_sel;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_t[$];
  int n_cmp = 0;
  int n_err = 0;
  int t_rx  = 0;
  logic prev_start = 1'b0;
  logic prev_idle  = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // transmit monitor
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      got_q.push_back(tx_data);
      got_t.push_back(cyc);
      chk("strobe_back_to_back", 64'(prev_start), 64'd0);
      chk("strobe_without_idle", 64'(prev_idle), 64'd1);
    end
    prev_start = tx_start;
    prev_idle  = tx_idle;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int th_of(input int k);
    logic [W-1:0] v;
    v = th_flat[k*W +: W];
    return int'($signed(v));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) m_th[k] = def_v[k];
    m_sel = 0;
  endtask

  task automatic model_cmd(input logic [7:0] b);
    int v;
    if (b >= 8'h41 && int'(b) < 8'h41 + NCH) begin
      exp_q.push_back(b);
      m_sel = int'(b) - 8'h41;
    end else if (b == "w" || b == "s" || b == "z" || b == "r") begin
      exp_q.push_back(b);
      v = m_th[m_sel];
      if (b == "w") v = v + step_v[m_sel];
      if (b == "s") v = v - step_v[m_sel];
      if (b == "w" || b == "s") begin
        if (v > max_v[m_sel]) v = max_v[m_sel];
        if (v < min_v[m_sel]) v = min_v[m_sel];
      end
      if (b == "z") v = def_v[m_sel];
      m_th[m_sel] = v;
      exp_q.push_back(8'(v & 255));
      exp_q.push_back(8'((v >>> 8) & 255));
    end else begin
`ifdef THB_ERR_NAK_EN
      exp_q.push_back(8'h3F);
`endif
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    t_rx     = cyc;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    int n;
    chk({tag, "_tx_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_tx_byte"}, 64'(got_q[i]), 64'(exp_q[i]));
    for (int k = 0; k < NCH; k++) chk({tag, "_th"}, 64'(th_of(k)), 64'(m_th[k]));
    chk({tag, "_sel_ch"}, 64'(sel_ch), 64'(m_sel));
  endtask

  task automatic run_cmd(input logic [7:0] b, input bit noisy, input string tag);
    int n;
    got_q.delete();
    got_t.delete();
    exp_q.delete();
    model_cmd(b);
    send_byte(b);
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      if (noisy) begin
        tx_idle = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0) begin
          rx_data  = 8'($urandom_range(0, 255));
          rx_valid = 1'b1;
        end
      end
      step();
      rx_valid = 1'b0;
      n++;
    end
    tx_idle = 1'b1;
    chk({tag, "_done_timeout"}, 64'(busy), 64'd0);
    compare_all(tag);
  endtask

  initial begin
    int n;
    int t_rise;
    logic [7:0] b;

    model_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk("reset_tx_start", 64'(tx_start), 64'd0);
    chk("reset_tx_data", 64'(tx_data), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    exp_q.delete();
    got_q.delete();
    compare_all("reset");

    // read back default ch0 with latency checks
    run_cmd("r", 1'b0, "read_default");
    if (got_t.size() >= 3) begin
      chk("lat_echo", 64'(got_t[0] - t_rx), 64'd2);
      chk("lat_byte0", 64'(got_t[1] - got_t[0]), 64'd3);
      chk("lat_byte1", 64'(got_t[2] - got_t[1]), 64'd2);
    end else begin
      chk("lat_strobes_seen", 64'(got_t.size()), 64'd3);
    end

    // ch1 saturates at its upper bound
    run_cmd("B", 1'b0, "sel_b");
    for (int i = 0; i < 20; i++) run_cmd("w", 1'b0, "inc_ch1");
    chk("ch1_at_max", 64'(th_of(1)), 64'd50);

    // ch2 saturates at its lower bound, then restore
    run_cmd("C", 1'b0, "sel_c");
    for (int i = 0; i < 40; i++) run_cmd("s", 1'b0, "dec_ch2");
    chk("ch2_at_min", 64'(th_of(2)), -64'sd12);
    run_cmd("z", 1'b0, "restore_ch2");

    // transmitter held busy: nothing goes out, extra bytes are dropped
    run_cmd("A", 1'b0, "sel_a");
    got_q.delete();
    got_t.delete();
    exp_q.delete();
    model_cmd("w");
    tx_idle = 1'b0;
    send_byte("w");
    for (int i = 0; i < 100; i++) begin
      if (i % 17 == 3) begin
        rx_data  = (i % 2 == 0) ? 8'h7A : 8'h42;
        rx_valid = 1'b1;
      end
      step();
      rx_valid = 1'b0;
    end
    chk("stall_no_strobe", 64'(got_q.size()), 64'd0);
    chk("stall_busy", 64'(busy), 64'd1);
    tx_idle = 1'b1;
    t_rise  = cyc;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("stall_done_timeout", 64'(busy), 64'd0);
    if (got_t.size() > 0) chk("stall_echo_time", 64'(got_t[0] - t_rise), 64'd1);
    else chk("stall_echo_seen", 64'(got_t.size()), 64'd1);
    compare_all("stall_inc");
    chk("ch0_2600", 64'(th_of(0)), 64'd2600);

    // reset in the middle of the value bytes
    run_cmd("D", 1'b0, "sel_d");
    run_cmd("w", 1'b0, "inc_ch3");
    got_q.delete();
    got_t.delete();
    send_byte("r");
    n = 0;
    while (got_q.size() < 2 && n < 100) begin
      step();
      n++;
    end
    chk("mid_bytes_before_reset", 64'(got_q.size()), 64'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    chk("mid_reset_tx_start", 64'(tx_start), 64'd0);
    chk("mid_reset_busy", 64'(busy), 64'd0);
    chk("mid_reset_tx_data", 64'(tx_data), 64'd0);
    repeat (6) step();
    chk("mid_reset_no_more_tx", 64'(got_q.size()), 64'd2);
    exp_q.delete();
    got_q.delete();
    compare_all("mid_reset");

    // out-of-range channel and unknown byte
    run_cmd("H", 1'b0, "bad_sel");
    run_cmd("x", 1'b0, "bad_cmd");

    // randomized command stream with transmitter stalls and dropped bytes
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: b = 8'(8'h41 + $urandom_range(0, 8));
        3, 4:    b = "w";
        5, 6:    b = "s";
        7:       b = "z";
        8:       b = "r";
        default: b = 8'($urandom_range(0, 255));
      endcase
      run_cmd(b, 1'b1, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_threshold_bank.md
Name: uart_threshold_bank

Overview:
Parametrised byte-command threshold register bank, the successor to the fixed seven-threshold UART controller. It holds NUM_CH signed thresholds of TH_WIDTH bits, each with its own step, bounds and default. It consumes the byte stream from the existing uart receiver and drives its transmitter. Commands select, nudge, restore or read back a channel, and every value is reported LS-byte-first. Sits between the uart core and the climate-control datapath that consumes th_flat.

Parameters:
NUM_CH, 7, number of threshold channels (1..26; channel k selected by ASCII 'A'+k)
TH_WIDTH, 16, bits per threshold, signed two's complement (2..32)
TH_DEFAULT, {16'sd16,16'sd35,16'sd16,16'sd35,16'sd16,16'sd35,16'sd2550}, packed NUM_CH*TH_WIDTH reset/restore values, ch0 in LSBs
TH_STEP, {16'd1 x6, 16'd50}, packed per-channel increment (unsigned, nonzero)
TH_MIN, {-12,32,-12,32,-12,32,50}, packed per-channel signed lower bound
TH_MAX, {27,50,27,50,27,50,5000}, packed per-channel signed upper bound

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_data  in  8  received byte from uart
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_idle  in  1  uart transmitter ready
tx_data  out  8  byte to transmit
tx_start  out  1  one-cycle transmit strobe
sel_ch  out  5  currently selected channel
th_flat  out  NUM_CH*TH_WIDTH  all thresholds, ch0 in LSBs
busy  out  1  high whenever state != S_IDLE

Behaviour:
- Reset (sync, rst high at clk edge): th[k]=TH_DEFAULT[k], sel_ch=0, tx_start=0, tx_data=0, state S_IDLE, busy=0. Mid-sequence reset aborts all pending bytes. tx_start is 0 the cycle after reset.
- NBYTES = ceil(TH_WIDTH/8). A reported value is sign-extended to NBYTES*8 bits and sent LS byte first.
- Commands are accepted only in S_IDLE on rx_valid. Bytes arriving in any other state are dropped silently.
  - 'A'..'A'+NUM_CH-1: latch channel.
  - 'w': increment.
  - 's': decrement.
  - 'z': restore default.
  - 'r': read back.
  - Any other byte: ignored. Codes 'A'+k with k>=NUM_CH are also ignored.
- FSM states: S_IDLE, S_ECHO, S_GAP, S_UPDATE, S_TX, S_TXGAP.
  - S_IDLE: on an accepted command, register it and go to S_ECHO.
  - S_ECHO: wait for tx_idle. Then tx_data=command byte, tx_start=1 for exactly one cycle, go to S_GAP.
  - S_GAP: one cycle, so that tx_idle is never sampled in the cycle after tx_start. Select commands apply sel_ch here and return to S_IDLE. 'w'/'s'/'z'/'r' go to S_UPDATE.
  - S_UPDATE: one cycle, modifies th[sel_ch]; byte index is cleared to 0.
  - S_TX: wait for tx_idle. Then send byte[index] with a tx_start pulse, go to S_TXGAP.
  - S_TXGAP: one cycle. If index==NBYTES-1, go to S_IDLE; else index+1 and return to S_TX.
- S_UPDATE arithmetic: computed at TH_WIDTH+2 bits signed so no intermediate overflow is possible.
  - 'w': th = min(th+step, max).
  - 's': th = max(th-step, min). Saturation clamps exactly to the bound (not "no change").
  - 'z': th = default.
  - 'r': no change.
- A value already outside [min,max] (impossible after reset) is clamped by the next 'w'/'s'.
- tx_start is never high two consecutive cycles and never asserted while tx_idle=0.
- Minimum latency, tx_idle held high: echo strobe 2 cycles after rx_valid. First value byte 3 cycles after the echo strobe, subsequent bytes every 2 cycles.
- th_flat and sel_ch are registered. th changes are visible the cycle after S_UPDATE.

Optional Feature:
THB_ERR_NAK_EN:
- Defined: an unrecognised or out-of-range byte received in S_IDLE is answered through the S_ECHO/S_GAP path with 0x3F ('?'). No register changes.
- Undefined: such bytes are ignored with no transmission.
- Default build leaves it undefined.

Test Plan:
1. Reset, defaults, tx_idle=1, send 'r' -> echo 0x72, then 0xF6, 0x09 (2550). th_flat ch0=2550, sel_ch=0.
2. Send 'B', 'w' x20 -> echoes 0x42, 0x77. ch1 saturates at 50 (0x32) and stays 50 on later 'w'. Other channels unchanged.
3. Send 'C', 's' x40 -> ch2 reaches -12, last report 0xF4 0xFF. Then 'z' -> ch2=16, report 0x10 0x00.
4. Hold tx_idle=0 for 100 cycles after 'w' on ch0 -> no tx_start while low. Echo issued 1 cycle after tx_idle rises. Value 2600 = 0x28, 0x0A. Extra rx_valid bytes during busy are dropped.
5. Assert rst during the second value byte -> next cycle tx_start=0, busy=0, all channels at defaults, sel_ch=0.
6. Send 'H' and 'x' -> no tx_start, no state change. With THB_ERR_NAK_EN defined, each produces a single 0x3F.
